// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup on the fetch PC, trained on the clock edge by resolved branches.
module branch_target_buffer #(
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [1:0]       ctr_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [31:0]      tgt_q [DEPTH];
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [1:0]       up_ctr;
    logic [1:0]       up_ctr_d;
    logic             up_wr_ctr, up_alloc, up_wr_tgt;

    assign lk_idx = pc_if[IDX_W+1:2];
    assign lk_tag = pc_if[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    // Lookup reads pre-edge contents only; no bypass from a same-cycle update.
    always_comb begin
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? tgt_q[lk_idx] : (pc_if + 32'd4);
    end

    always_comb begin
        mispredict = upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    end

    always_comb begin
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr    = ctr_q[up_idx];
        up_ctr_d  = up_ctr;
        up_wr_ctr = 1'b0;
        up_alloc  = 1'b0;
        up_wr_tgt = 1'b0;
        if (upd_valid) begin
            if (up_hit) begin
                up_wr_ctr = 1'b1;
                if (upd_taken) begin
                    up_ctr_d  = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
                    up_wr_tgt = 1'b1;
                end else begin
                    up_ctr_d  = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                up_alloc  = 1'b1;
                up_wr_ctr = 1'b1;
                up_wr_tgt = 1'b1;
                up_ctr_d  = CTR_INIT;
            end
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_valid) begin
            br_count_d = br_count_q + 32'd1;
            if (mispredict) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= '0;
            ctr_q           <= '{default: '0};
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
            if (up_alloc) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (up_wr_ctr) begin
                ctr_q[up_idx] <= up_ctr_d;
            end
        end
    end

    // Tag/target carry no reset: they are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && up_alloc) begin
            tag_q[up_idx] <= up_tag;
        end
        if (rst_n && up_wr_tgt) begin
            tgt_q[up_idx] <= upd_target;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer against an array-based reference model.
module tb_branch_target_buffer;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ENTRIES = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int total;
    int bad;

    branch_target_buffer #(.IDX_W(IDX_W), .CTR_INIT(2'b10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_if          (pc_if),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict     (mispredict),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per index, counters as plain integers.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic logic [32:0] model_lookup(input logic [31:0] pc);
        int  idx;
        bit  hit;
        idx = int'((pc >> 2) % ENTRIES);
        hit = m_valid[idx] && (m_tag[idx] == (pc >> 6));
        if (hit && m_ctr[idx] >= 2) return {1'b1, m_tgt[idx]};
        return {1'b0, pc + 32'd4};
    endfunction

    function automatic bit model_mispred();
        if (!upd_valid) return 0;
        if (upd_taken != upd_pred_taken) return 1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    function automatic void model_commit();
        int idx;
        bit hit;
        if (!rst_n || !upd_valid) return;
        idx = int'((upd_pc >> 2) % ENTRIES);
        hit = m_valid[idx] && (m_tag[idx] == (upd_pc >> 6));
        m_br = m_br + 1;
        if (model_mispred()) m_mp = m_mp + 1;
        if (hit) begin
            if (upd_taken) begin
                m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                m_tgt[idx] = upd_target;
            end else begin
                m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end
        end else if (upd_taken) begin
            m_valid[idx] = 1;
            m_tag[idx]   = upd_pc >> 6;
            m_tgt[idx]   = upd_target;
            m_ctr[idx]   = 2;
        end
    endfunction

    task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                             input logic ptk, input logic [31:0] ptg);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_commit();
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [32:0] m;
        rst_n = 1'b0;
        pc_if = 32'h0040_0010;
        upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        model_reset();
        #2;
        m = model_lookup(pc_if);
        total++; if (pred_taken !== m[32]) begin bad++; $display("FAIL reset_pt: got %0h want %0h", pred_taken, m[32]); end
        total++; if (pred_target !== 32'h0040_0014) begin bad++; $display("FAIL reset_tgt: got %h want %h", pred_target, 32'h0040_0014); end
        total++; if (br_count !== 32'd0) begin bad++; $display("FAIL reset_br: got %0d want 0", br_count); end
        total++; if (mispred_count !== 32'd0) begin bad++; $display("FAIL reset_mp: got %0d want 0", mispred_count); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alloc();
        pc_if = 32'h0040_0010;
        drive_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        #1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mispred: got %0h want 1", mispredict); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alloc_pre_pt: got %0h want 0", pred_taken); end
        clock_edge();
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_pt: got %0h want 1", pred_taken); end
        total++; if (pred_target !== 32'h0040_0040) begin bad++; $display("FAIL alloc_tgt: got %h want %h", pred_target, 32'h0040_0040); end
        total++; if (mispred_count !== 32'd1) begin bad++; $display("FAIL alloc_mp: got %0d want 1", mispred_count); end
        total++; if (br_count !== 32'd1) begin bad++; $display("FAIL alloc_br: got %0d want 1", br_count); end
    endtask

    task automatic test_saturation();
        // taken x3 (ctr saturates at 3), not-taken x2 (ctr 1), taken (ctr 2)
        logic [5:0] dirs;
        logic [5:0] exp_pt;
        logic [32:0] m;
        dirs   = 6'b100111;
        exp_pt = 6'b101111;
        pc_if  = 32'h0040_0010;
        for (int i = 0; i < 6; i++) begin
            drive_upd(32'h0040_0010, dirs[i], 32'h0040_0040, 1'b1, 32'h0040_0040);
            #1;
            total++; if (mispredict !== !dirs[i]) begin bad++; $display("FAIL sat_mispred[%0d]: got %0h want %0h", i, mispredict, !dirs[i]); end
            clock_edge();
            m = model_lookup(pc_if);
            total++; if (pred_taken !== exp_pt[i] || pred_taken !== m[32]) begin bad++; $display("FAIL sat_pt[%0d]: got %0h want %0h", i, pred_taken, exp_pt[i]); end
        end
        total++; if (br_count !== 32'd7) begin bad++; $display("FAIL sat_br: got %0d want 7", br_count); end
        total++; if (mispred_count !== m_mp) begin bad++; $display("FAIL sat_mp: got %0d want %0d", mispred_count, m_mp); end
    endtask

    task automatic test_alias();
        drive_upd(32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0054);
        clock_edge();
        pc_if = 32'h0040_0010;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_old_pt: got %0h want 0", pred_taken); end
        total++; if (pred_target !== 32'h0040_0014) begin bad++; $display("FAIL alias_old_tgt: got %h want %h", pred_target, 32'h0040_0014); end
        pc_if = 32'h0040_0050;
        #1;
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_new_pt: got %0h want 1", pred_taken); end
        total++; if (pred_target !== 32'h0040_0100) begin bad++; $display("FAIL alias_new_tgt: got %h want %h", pred_target, 32'h0040_0100); end
    endtask

    task automatic test_same_cycle();
        pc_if = 32'h0040_0050;
        drive_upd(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100);
        #1;
        total++; if (pred_target !== 32'h0040_0100) begin bad++; $display("FAIL same_pre_tgt: got %h want %h", pred_target, 32'h0040_0100); end
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL same_mispred: got %0h want 1", mispredict); end
        clock_edge();
        total++; if (pred_target !== 32'h0040_0200) begin bad++; $display("FAIL same_post_tgt: got %h want %h", pred_target, 32'h0040_0200); end
        pc_if = 32'hFFFF_FFFC;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL wrap_pt: got %0h want 0", pred_taken); end
        total++; if (pred_target !== 32'h0000_0000) begin bad++; $display("FAIL wrap_tgt: got %h want 00000000", pred_target); end
    endtask

    task automatic test_random();
        logic [31:0] bases [4];
        logic [32:0] m;
        logic [31:0] pc;
        bases[0] = 32'h0040_0000;
        bases[1] = 32'h0040_0040;
        bases[2] = 32'h1000_0000;
        bases[3] = 32'hFFFF_FFC0;
        for (int i = 0; i < 300; i++) begin
            pc_if = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            pc    = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15) * 4);
            m     = model_lookup(pc);
            if ($urandom_range(0, 3) != 0) begin
                drive_upd(pc, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) != 0) ? m[31:0] : {$urandom_range(0, 255), 2'b00},
                          ($urandom_range(0, 4) == 0) ? !m[32] : m[32], m[31:0]);
            end else begin
                upd_valid = 1'b0;
            end
            #1;
            m = model_lookup(pc_if);
            total++; if (pred_taken !== m[32]) begin bad++; $display("FAIL rnd_pt[%0d]: got %0h want %0h", i, pred_taken, m[32]); end
            total++; if (pred_target !== m[31:0]) begin bad++; $display("FAIL rnd_tgt[%0d]: got %h want %h", i, pred_target, m[31:0]); end
            total++; if (mispredict !== model_mispred()) begin bad++; $display("FAIL rnd_mispred[%0d]: got %0h want %0h", i, mispredict, model_mispred()); end
            clock_edge();
            total++; if (br_count !== m_br) begin bad++; $display("FAIL rnd_br[%0d]: got %0d want %0d", i, br_count, m_br); end
            total++; if (mispred_count !== m_mp) begin bad++; $display("FAIL rnd_mp[%0d]: got %0d want %0d", i, mispred_count, m_mp); end
        end
    endtask

    task automatic test_async_reset();
        drive_upd(32'h0040_0090, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300);
        clock_edge();
        pc_if = 32'h0040_0090;
        #2;
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL arst_pre_pt: got %0h want 1", pred_taken); end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_pt: got %0h want 0", pred_taken); end
        total++; if (pred_target !== 32'h0040_0094) begin bad++; $display("FAIL arst_tgt: got %h want %h", pred_target, 32'h0040_0094); end
        total++; if (br_count !== 32'd0) begin bad++; $display("FAIL arst_br: got %0d want 0", br_count); end
        total++; if (mispred_count !== 32'd0) begin bad++; $display("FAIL arst_mp: got %0d want 0", mispred_count); end
        drive_upd(32'h0040_0090, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0094);
        clock_edge();
        #3;
        rst_n = 1'b1;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_post_pt: got %0h want 0", pred_taken); end
        total++; if (br_count !== 32'd0) begin bad++; $display("FAIL arst_post_br: got %0d want 0", br_count); end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        fork
            begin
                test_reset();
                test_alloc();
                test_saturation();
                test_alias();
                test_same_cycle();
                test_random();
                test_async_reset();
            end
            begin
                #100000;
                bad++;
                $display("FAIL timeout: got no completion want completion within budget");
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the program counter.
- Looks up the current fetch PC combinationally and supplies the predicted next fetch address, selected by the pred_taken select.
- Trained at the clock edge by resolved branch/jump outcomes from the ID/EX stage.
- Keeps 32-bit branch and mispredict counters for performance debug.

Parameters:
- IDX_W, 4, index width; the buffer holds 2^IDX_W entries.
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pc_if  input  32  current fetch PC (PC output)
- pred_taken  output  1  1 = fetch should redirect to pred_target
- pred_target  output  32  predicted next PC; pc_if+4 when not taken
- upd_valid  input  1  a resolved branch/jump is presented this cycle
- upd_pc  input  32  PC of the resolved instruction
- upd_taken  input  1  actual direction
- upd_target  input  32  actual taken target
- upd_pred_taken  input  1  prediction carried down the pipeline with the instruction
- upd_pred_target  input  32  predicted target carried down the pipeline
- mispredict  output  1  combinational; valid only when upd_valid=1
- br_count  output  32  number of updates accepted
- mispred_count  output  32  number of mispredicts

Behaviour:
- Reset (async, rst_n=0) clears every entry's valid bit and counter to 0, and clears br_count and mispred_count to 0. Tag and target contents are don't-care.
- Outputs during reset: pred_taken=0, pred_target=pc_if+4.
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] is ignored.
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Lookup is combinational, zero latency:
  - hit = entry[idx(pc_if)].valid && tag matches.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? entry.target : pc_if+4, computed mod 2^32 (0xFFFFFFFC+4 = 0).
- Mispredict is combinational:
  - mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_pred_taken && upd_target != upd_pred_target)).
  - When upd_valid=0, mispredict=0.
- Update happens on posedge clk when upd_valid=1, and operates on entry e = idx(upd_pc).
  - Hit on upd_pc:
    - Taken: ctr = min(ctr+1, 3); target <= upd_target.
    - Not taken: ctr = max(ctr-1, 0); target is unchanged.
    - The entry stays valid even when ctr reaches 0.
  - Miss, taken: allocate. valid=1, tag=tag(upd_pc), target=upd_target, ctr=CTR_INIT. Any existing entry at that index is replaced, with no victim logic.
  - Miss, not taken: no change.
  - br_count increments by 1.
  - mispred_count increments by 1 when mispredict=1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Simultaneous lookup and update on the same index: lookup returns pre-edge contents; there is no write-through bypass. The new contents are visible the cycle after the edge.
- No stall input: a PC stall does not affect the buffer because lookup is purely combinational. The pipeline must deassert upd_valid for a flushed or bubbled instruction.
- Reset asserted mid-operation: all state is cleared immediately. A pending update at the next edge is ignored while rst_n=0.

Test Plan:
- Reset, then pc_if=0x00400010 -> pred_taken=0, pred_target=0x00400014; br_count=0 and mispred_count=0.
- Update upd_pc=0x00400010, taken, target 0x00400040, pred_taken=0 -> mispredict=1 that cycle. Next cycle pc_if=0x00400010 gives pred_taken=1, pred_target=0x00400040; mispred_count=1, br_count=1.
- Saturation sequence:
  - Three taken updates on the same PC -> ctr=3.
  - Then two not-taken updates -> ctr=1 and pred_taken=0.
  - Then one taken update -> ctr=2 and pred_taken=1.
  - Checks saturation at 3 and the direction flip at the ctr[1] boundary.
- Aliasing: allocate 0x00400010, then a taken update at 0x00400050 (same index, different tag) -> lookup at 0x00400010 misses (pred_target=0x00400014), and 0x00400050 hits with the new target.
- Same-cycle lookup and update on one index -> pred_target reflects old contents in that cycle and new contents next cycle. Separately, pc_if=0xFFFFFFFC on a miss gives pred_target=0x00000000.
- Assert rst_n low asynchronously mid-cycle after training -> pred_taken drops to 0 without a clock edge; counters read 0; after release, the first lookup misses.
